// File: rtl/snn_infer_ctrl_pkg.sv
// Shared definitions for the spiking-classifier inference sequencer:
// controller state encoding and network dimensions used by counters and top level.
package snn_infer_ctrl_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned WIDTH_P     = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClear  = 3'd1,
        StRun    = 3'd2,
        StSettle = 3'd3,
        StScan   = 3'd4,
        StDone   = 3'd5
    } state_e;

endpackage

// File: rtl/snn_argmax_scan.sv
// Serial running-max stage: one counter value per cycle, lowest index wins ties.
// Exposes next-state values so the caller can capture the final result on the last compare.
module snn_argmax_scan #(
    parameter int unsigned WIDTH_P = snn_infer_ctrl_pkg::WIDTH_P,
    parameter int unsigned SEL_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               cmp_en_i,
    input  logic [SEL_W-1:0]   idx_i,
    input  logic [WIDTH_P-1:0] count_i,
    output logic [WIDTH_P-1:0] max_next_o,
    output logic [SEL_W-1:0]   class_next_o,
    output logic               tie_next_o
);

    logic [WIDTH_P-1:0] max_q, max_d;
    logic [SEL_W-1:0]   class_q, class_d;
    logic               tie_q, tie_d;

    always_comb begin
        max_d   = max_q;
        class_d = class_q;
        tie_d   = tie_q;
        if (load_i) begin
            max_d   = count_i;
            class_d = idx_i;
            tie_d   = 1'b0;
        end else if (cmp_en_i) begin
            if (count_i > max_q) begin
                max_d   = count_i;
                class_d = idx_i;
                tie_d   = 1'b0;
            end else if (count_i == max_q) begin
                tie_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_q   <= '0;
            class_q <= '0;
            tie_q   <= 1'b0;
        end else begin
            max_q   <= max_d;
            class_q <= class_d;
            tie_q   <= tie_d;
        end
    end

    assign max_next_o   = max_d;
    assign class_next_o = class_d;
    assign tie_next_o   = tie_d;

endmodule

// File: rtl/snn_infer_ctrl.sv
// Inference sequencer: clear, run N timesteps, settle, then serially scan the
// output spike counters for the winning class.
module snn_infer_ctrl #(
    parameter int unsigned NUM_CLASSES = snn_infer_ctrl_pkg::NUM_CLASSES,
    parameter int unsigned WIDTH_P     = snn_infer_ctrl_pkg::WIDTH_P,
    parameter int unsigned STEP_W      = 8,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned SEL_W       = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [STEP_W-1:0]  num_steps_i,
    output logic               net_clear_o,
    output logic               net_en_o,
    output logic [SEL_W-1:0]   count_sel_o,
    input  logic [WIDTH_P-1:0] count_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [SEL_W-1:0]   class_o,
    output logic [WIDTH_P-1:0] max_count_o,
    output logic               tie_o
);

    import snn_infer_ctrl_pkg::*;

    localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SetW-1:0]  SettleLoad = SetW'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] LastIdx    = SEL_W'(NUM_CLASSES - 1);

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [SetW-1:0]    settle_q, settle_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [SEL_W-1:0]   class_q, class_d;
    logic [WIDTH_P-1:0] max_q, max_d;
    logic               tie_q, tie_d;

    logic               scan_load, scan_en, res_load;
    logic [WIDTH_P-1:0] run_max;
    logic [SEL_W-1:0]   run_class;
    logic               run_tie;

    snn_argmax_scan #(
        .WIDTH_P (WIDTH_P),
        .SEL_W   (SEL_W)
    ) u_argmax (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (scan_load),
        .cmp_en_i     (scan_en),
        .idx_i        (idx_q),
        .count_i      (count_i),
        .max_next_o   (run_max),
        .class_next_o (run_class),
        .tie_next_o   (run_tie)
    );

    always_comb begin
        state_d     = state_q;
        steps_d     = steps_q;
        settle_d    = settle_q;
        idx_d       = idx_q;
        net_clear_o = 1'b0;
        net_en_o    = 1'b0;
        count_sel_o = '0;
        done_o      = 1'b0;
        scan_load   = 1'b0;
        scan_en     = 1'b0;
        res_load    = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    steps_d = num_steps_i;
                    state_d = StClear;
                end
            end
            StClear: begin
                net_clear_o = 1'b1;
                if (steps_q == '0) begin
                    settle_d = SettleLoad;
                    state_d  = StSettle;
                end else begin
                    state_d  = StRun;
                end
            end
            StRun: begin
                net_en_o = 1'b1;
                steps_d  = steps_q - STEP_W'(1);
                if (steps_q == STEP_W'(1)) begin
                    settle_d = SettleLoad;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_q == '0) begin
                    idx_d   = '0;
                    state_d = StScan;
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            StScan: begin
                count_sel_o = idx_q;
                scan_en     = 1'b1;
                scan_load   = (idx_q == '0);
                if (idx_q == LastIdx) begin
                    // Capture the post-compare running values so results are valid in DONE.
                    res_load = 1'b1;
                    idx_d    = '0;
                    state_d  = StDone;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort_i && (state_q != StIdle)) begin
            state_d  = StIdle;
            res_load = 1'b0;
        end
    end

    always_comb begin
        class_d = class_q;
        max_d   = max_q;
        tie_d   = tie_q;
        if (res_load) begin
            class_d = run_class;
            max_d   = run_max;
            tie_d   = run_tie;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            steps_q  <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            class_q  <= '0;
            max_q    <= '0;
            tie_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            steps_q  <= steps_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            class_q  <= class_d;
            max_q    <= max_d;
            tie_q    <= tie_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign class_o     = class_q;
    assign max_count_o = max_q;
    assign tie_o       = tie_q;

endmodule

// File: tb/tb_snn_infer_ctrl.sv
// Self-checking bench for snn_infer_ctrl: the bench plays the spike counters and
// checks timing and argmax results against a plain reference model.
module tb_snn_infer_ctrl;

    localparam int unsigned NC   = 10;
    localparam int unsigned WP   = 8;
    localparam int unsigned SW   = 8;
    localparam int unsigned SC   = 2;
    localparam int unsigned SELW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            abort;
    logic [SW-1:0]   num_steps;
    logic            net_clear;
    logic            net_en;
    logic [SELW-1:0] count_sel;
    logic [WP-1:0]   count;
    logic            busy;
    logic            done;
    logic [SELW-1:0] cls;
    logic [WP-1:0]   max_count;
    logic            tie;

    logic [WP-1:0]   cnts [NC];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    int clr_cyc = -1;

    snn_infer_ctrl #(
        .NUM_CLASSES (NC),
        .WIDTH_P     (WP),
        .STEP_W      (SW),
        .SETTLE_CYC  (SC),
        .SEL_W       (SELW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .num_steps_i (num_steps),
        .net_clear_o (net_clear),
        .net_en_o    (net_en),
        .count_sel_o (count_sel),
        .count_i     (count),
        .busy_o      (busy),
        .done_o      (done),
        .class_o     (cls),
        .max_count_o (max_count),
        .tie_o       (tie)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        count = '0;
        if (int'(count_sel) < NC) count = cnts[int'(count_sel)];
    end

    // Cycle c is the period following active edge c-1.
    always @(negedge clk) begin
        if (net_en) en_cnt++;
        if (net_clear) begin
            clr_cnt++;
            clr_cyc = cyc + 1;
        end
        if (done) done_cnt++;
    end

    function automatic void model(output int ecls, output int emx, output bit etie);
        int n;
        emx = -1;
        ecls = 0;
        n = 0;
        for (int i = 0; i < NC; i++) begin
            if (int'(cnts[i]) > emx) begin
                emx = int'(cnts[i]);
                ecls = i;
            end
        end
        for (int i = 0; i < NC; i++) if (int'(cnts[i]) == emx) n++;
        etie = (n > 1);
    endfunction

    task automatic set_counts(input int c0, input int c1, input int c2, input int c3,
                              input int c4, input int c9);
        for (int i = 0; i < NC; i++) cnts[i] = '0;
        cnts[0] = WP'(c0);
        cnts[1] = WP'(c1);
        cnts[2] = WP'(c2);
        cnts[3] = WP'(c3);
        cnts[4] = WP'(c4);
        cnts[9] = WP'(c9);
    endtask

    task automatic wait_done(input int budget, output bit got, output int dcyc);
        got = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                dcyc = cyc + 1;
                break;
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL done_timeout: no done within %0d cycles, required one", budget);
        end
    endtask

    task automatic run_check(input string nm, input int n);
        int  k, e0, c0, d0, ecls, emx, dcyc, exp_done;
        bit  etie, got;
        model(ecls, emx, etie);
        @(negedge clk);
        e0 = en_cnt;
        c0 = clr_cnt;
        d0 = done_cnt;
        num_steps = SW'(n);
        start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        num_steps = SW'($urandom);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy: got %b need 1", nm, busy);
        end
        wait_done(n + 40, got, dcyc);
        exp_done = k + 2 + n + SC + NC;
        n_cmp++;
        if (dcyc != exp_done) begin
            n_bad++;
            $display("FAIL %s done_cycle: got %0d need %0d", nm, dcyc, exp_done);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (clr_cnt - c0 != 1 || clr_cyc != k + 1) begin
            n_bad++;
            $display("FAIL %s clear: got %0d pulses at %0d need 1 at %0d",
                     nm, clr_cnt - c0, clr_cyc, k + 1);
        end
        n_cmp++;
        if (en_cnt - e0 != n) begin
            n_bad++;
            $display("FAIL %s enable_cycles: got %0d need %0d", nm, en_cnt - e0, n);
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL %s done_pulses: got %0d need 1", nm, done_cnt - d0);
        end
        n_cmp++;
        if (int'(cls) != ecls || int'(max_count) != emx || tie !== etie) begin
            n_bad++;
            $display("FAIL %s result: got class %0d max %0d tie %b need class %0d max %0d tie %b",
                     nm, cls, max_count, tie, ecls, emx, etie);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle_after: got busy %b done %b need 0 0", nm, busy, done);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({net_clear, net_en, count_sel, busy, done, cls, max_count, tie} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b need all 0",
                     {net_clear, net_en, count_sel, busy, done, cls, max_count, tie});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        set_counts(1, 2, 8, 3, 0, 0);
        run_check("pre_reset", 4);
        @(negedge clk);
        num_steps = 8'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && seen < 5; i++) begin
            @(negedge clk);
            if (net_en) seen++;
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({net_clear, net_en, count_sel, busy, done, cls, max_count, tie} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_run: got %b need all 0 (en seen %0d)",
                     {net_clear, net_en, count_sel, busy, done, cls, max_count, tie}, seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_counts(0, 4, 1, 0, 6, 2);
        run_check("after_reset", 7);
    endtask

    task automatic test_basic();
        set_counts(3, 9, 4, 0, 0, 0);
        run_check("basic", 20);
        n_cmp++;
        if (cls !== 4'd1 || max_count !== 8'd9 || tie !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_const: got %0d/%0d/%b need 1/9/0", cls, max_count, tie);
        end
    endtask

    task automatic test_ties();
        set_counts(5, 2, 7, 7, 0, 7);
        run_check("tie_727", 3);
        set_counts(0, 0, 0, 0, 0, 0);
        run_check("all_zero", 1);
    endtask

    task automatic test_step_bounds();
        set_counts(2, 2, 3, 1, 0, 0);
        run_check("steps_0", 0);
        set_counts(0, 0, 0, 0, 0, 11);
        run_check("steps_255", 255);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NC; i++) cnts[i] = WP'($urandom_range(0, 6));
            run_check("random", int'($urandom_range(0, 30)));
        end
    endtask

    task automatic test_back_to_back();
        int  k, d0, dcyc;
        bit  got;
        set_counts(1, 1, 1, 9, 1, 1);
        @(negedge clk);
        d0 = done_cnt;
        num_steps = 8'd20;
        start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        num_steps = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(60, got, dcyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_start_at_done: got busy %b need 0", busy);
        end
        n_cmp++;
        if (dcyc != k + 34) begin
            n_bad++;
            $display("FAIL b2b_done_cycle: got %0d need %0d", dcyc, k + 34);
        end
        repeat (30) @(negedge clk);
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL b2b_done_pulses: got %0d need 1", done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        int  d0, ecls, emx;
        bit  etie, hit;
        set_counts(0, 3, 0, 0, 0, 5);
        run_check("pre_abort", 2);
        model(ecls, emx, etie);
        set_counts(9, 0, 0, 0, 0, 0);
        @(negedge clk);
        d0 = done_cnt;
        num_steps = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && count_sel == 4'd4) begin
                hit = 1'b1;
                break;
            end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if (!hit || busy !== 1'b0 || net_en !== 1'b0 || net_clear !== 1'b0 || count_sel !== '0) begin
            n_bad++;
            $display("FAIL abort_idle: got hit %b busy %b en %b clr %b sel %0d need 1 0 0 0 0",
                     hit, busy, net_en, net_clear, count_sel);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (done_cnt != d0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d pulses need 0", done_cnt - d0);
        end
        n_cmp++;
        if (int'(cls) != ecls || int'(max_count) != emx || tie !== etie) begin
            n_bad++;
            $display("FAIL abort_hold: got %0d/%0d/%b need %0d/%0d/%b",
                     cls, max_count, tie, ecls, emx, etie);
        end
        // Abort while idle must not block a start in the same cycle.
        set_counts(1, 0, 0, 4, 0, 0);
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        num_steps = 8'd2;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || net_clear !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_in_idle: got busy %b clr %b need 1 1", busy, net_clear);
        end
        repeat (30) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        num_steps = '0;
        for (int i = 0; i < NC; i++) cnts[i] = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_reset_mid_run();
        test_ties();
        test_step_bounds();
        test_random();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
